// File: rtl/regdst_arb_mux.sv
// Purpose: N-channel W-bit arbitrated mux (fixed-priority or round-robin) feeding one registered output word.
// Latency: 1 cycle from the accepting edge to out_valid with that word; full rate with no bubble while drained.
// Backpressure: while the output word is held (out_valid && !out_ready) every in_ready is 0 and the state is frozen.
module regdst_arb_mux #(
    parameter int WIDTH = 5,
    parameter int NCH   = 3,
    parameter int SELW  = 2,
    parameter int RR    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH*WIDTH-1:0]  in_data,
    input  logic [NCH-1:0]        in_valid,
    output logic [NCH-1:0]        in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_sel,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_sel_q,   out_sel_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  ptr_q,       ptr_d;

    logic [NCH-1:0]   grant;
    logic             gnt_any;
    logic [SELW-1:0]  gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             acc;
    logic             xfer;
    int               idx;
    logic [SELW-1:0]  idx_s;

    // Arbiter: scan upward from the start point (ptr in round-robin, 0 otherwise), wrapping; first valid wins.
    always_comb begin
        grant   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        idx_s   = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = k + ((RR != 0) ? int'(ptr_q) : 0);
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            idx_s = SELW'(idx);
            if (!gnt_any && in_valid[idx_s]) begin
                gnt_any      = 1'b1;
                grant[idx_s] = 1'b1;
                gnt_idx      = idx_s;
            end
        end
    end

    // Word mux driven by the one-hot grant, so no variable part-select is needed.
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Handshake and next-state: refill whenever the register is empty or being drained this cycle.
    always_comb begin
        acc         = !out_valid_q || out_ready;
        in_ready    = (rst && acc) ? grant : '0;
        xfer        = rst && acc && gnt_any;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_data_d  = gnt_data;
            out_sel_d   = gnt_idx;
            out_valid_d = 1'b1;
            if (RR != 0) begin
                ptr_d = (gnt_idx == SELW'(NCH - 1)) ? '0 : gnt_idx + SELW'(1);
            end
        end else if (out_ready) begin
            // Drain with nothing to refill: data and index keep their last values.
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset wins over any simultaneous transfer or drain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_regdst_arb_mux.sv
// Purpose: directed bench for regdst_arb_mux, one fixed-priority and one round-robin instance.
// Latency: expected words are queued as stimulus is driven and compared when the consumer takes them.
// Backpressure: the idle instance is held with no valid inputs and out_ready=1 while the other is exercised.
module tb_regdst_arb_mux;

    localparam int WIDTH = 5;
    localparam int NCH   = 3;
    localparam int SELW  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 mode;      // 0 = drive fixed-priority instance, 1 = round-robin instance
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic                 out_ready;

    logic [NCH-1:0]   fp_in_valid, rr_in_valid;
    logic             fp_out_ready, rr_out_ready;
    logic [NCH-1:0]   fp_in_ready, rr_in_ready;
    logic [WIDTH-1:0] fp_out_data, rr_out_data;
    logic [SELW-1:0]  fp_out_sel, rr_out_sel;
    logic             fp_out_valid, rr_out_valid;

    logic [NCH-1:0]   obs_ready;
    logic [WIDTH-1:0] obs_data;
    logic [SELW-1:0]  obs_sel;
    logic             obs_valid;

    int checks   = 0;
    int failures = 0;

    logic [SELW+WIDTH-1:0] exp_q[$];
    logic [SELW+WIDTH-1:0] sb_e;

    always #5 clk = ~clk;

    assign fp_in_valid  = mode ? '0 : in_valid;
    assign rr_in_valid  = mode ? in_valid : '0;
    assign fp_out_ready = mode ? 1'b1 : out_ready;
    assign rr_out_ready = mode ? out_ready : 1'b1;

    assign obs_ready = mode ? rr_in_ready  : fp_in_ready;
    assign obs_data  = mode ? rr_out_data  : fp_out_data;
    assign obs_sel   = mode ? rr_out_sel   : fp_out_sel;
    assign obs_valid = mode ? rr_out_valid : fp_out_valid;

    regdst_arb_mux #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .RR(0)) dut_fp (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(fp_in_valid),
        .in_ready(fp_in_ready), .out_data(fp_out_data), .out_sel(fp_out_sel),
        .out_valid(fp_out_valid), .out_ready(fp_out_ready)
    );

    regdst_arb_mux #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .RR(1)) dut_rr (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(rr_in_valid),
        .in_ready(rr_in_ready), .out_data(rr_out_data), .out_sel(rr_out_sel),
        .out_valid(rr_out_valid), .out_ready(rr_out_ready)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int sel, input int data);
        exp_q.push_back({SELW'(sel), WIDTH'(data)});
    endtask

    task automatic chk_out(input string tag, input int v, input int s, input int d);
        chk({tag, "_valid"}, int'(obs_valid), v);
        chk({tag, "_sel"},   int'(obs_sel),   s);
        chk({tag, "_data"},  int'(obs_data),  d);
    endtask

    // Scoreboard: a word is consumed when valid and ready meet at the coming edge.
    always @(negedge clk) begin
        if (rst && obs_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL sb_unexpected observed_sel=%0d observed_data=%0d expected=none",
                       obs_sel, obs_data);
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_sel",  int'(obs_sel),  int'(sb_e[SELW+WIDTH-1:WIDTH]));
                chk("sb_data", int'(obs_data), int'(sb_e[WIDTH-1:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rr_sel[6];
        int rr_dat[6];
        rr_sel = '{0, 1, 2, 0, 1, 2};
        rr_dat = '{3, 7, 31, 3, 7, 31};

        // Reset with every channel requesting.
        mode      = 1'b0;
        rst       = 1'b0;
        in_data   = {5'd31, 5'd7, 5'd3};
        in_valid  = 3'b111;
        out_ready = 1'b1;
        cyc();
        cyc();
        chk_out("rst_fp", 0, 0, 0);
        chk("rst_fp_in_ready", int'(fp_in_ready), 0);
        chk("rst_rr_valid", int'(rr_out_valid), 0);
        chk("rst_rr_data", int'(rr_out_data), 0);

        // Release: channel 0 transfers on the first edge.
        rst = 1'b1;
        #1;
        chk("rel_in_ready", int'(obs_ready), 1);
        push(0, 3);
        cyc();
        chk_out("rel_first", 1, 0, 3);

        // Fixed priority between channels 1 and 2.
        in_valid = 3'b110;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("fp_in_ready_110", int'(obs_ready), 2);
            push(1, 7);
            cyc();
            chk_out("fp_110", 1, 1, 7);
        end
        in_valid = 3'b100;
        #1;
        chk("fp_in_ready_100", int'(obs_ready), 4);
        push(2, 31);
        cyc();
        chk_out("fp_100", 1, 2, 31);
        in_valid = 3'b000;
        cyc();
        chk_out("fp_drain", 0, 2, 31);

        // Channel 0 starves the others.
        in_valid = 3'b111;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("fp_starve_ready", int'(obs_ready), 1);
            push(0, 3);
            cyc();
            chk_out("fp_starve", 1, 0, 3);
        end
        in_valid = 3'b000;
        cyc();

        // Round-robin wrap with everyone valid.
        mode     = 1'b1;
        in_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("rr_in_ready", int'(obs_ready), 1 << rr_sel[c]);
            push(rr_sel[c], rr_dat[c]);
            cyc();
            chk_out("rr_wrap", 1, rr_sel[c], rr_dat[c]);
        end
        in_valid = 3'b000;
        cyc();
        chk("rr_drained", int'(obs_valid), 0);

        // Backpressure: hold the first word for 4 cycles, then refill with no bubble.
        in_valid = 3'b111;
        push(0, 3);
        cyc();
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("bp_in_ready", int'(obs_ready), 0);
            cyc();
            chk_out("bp_hold", 1, 0, 3);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", int'(obs_ready), 2);
        push(1, 7);
        cyc();
        chk_out("bp_no_bubble", 1, 1, 7);
        in_valid = 3'b000;
        cyc();

        // Idle and sparse: a lone channel-2 request wraps the pointer back to 0.
        in_valid = 3'b100;
        push(2, 31);
        cyc();
        in_valid = 3'b000;
        chk_out("sparse_one", 1, 2, 31);
        cyc();
        chk("sparse_gone", int'(obs_valid), 0);
        cyc();
        chk("sparse_idle", int'(obs_valid), 0);
        in_valid = 3'b011;
        #1;
        chk("sparse_ptr0_ready", int'(obs_ready), 1);
        push(0, 3);
        cyc();
        chk_out("sparse_ptr0", 1, 0, 3);
        in_valid = 3'b000;
        cyc();

        // Reset mid-stall discards the held word and the pointer (which would otherwise be 2).
        in_valid = 3'b010;
        push(1, 7);
        cyc();
        out_ready = 1'b0;
        in_valid  = 3'b000;
        cyc();
        chk_out("stall_held", 1, 1, 7);
        void'(exp_q.pop_back());
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 3'b111;
        #1;
        chk("mid_rst_in_ready", int'(obs_ready), 0);
        cyc();
        rst      = 1'b1;
        in_valid = 3'b101;
        chk_out("mid_rst", 0, 0, 0);
        #1;
        chk("mid_rst_ptr0_ready", int'(obs_ready), 1);
        push(0, 3);
        cyc();
        chk_out("mid_rst_ptr0", 1, 0, 3);
        in_valid = 3'b000;
        cyc();
        cyc();
        chk("sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
